pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 17 +
 rtl/pipeline_ctrl_sat_counter16.sv | 23 ++
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings and
// default datapath widths (register address, data word, instruction word).
// No ports; imported by pipeline_ctrl and its sub-modules.
package pipeline_ctrl_pkg;

  localparam int DEF_ASIZE = 5;   // register-address width
  localparam int DEF_DSIZE = 32;  // data word width
  localparam int DEF_ISIZE = 32;  // instruction word width

  // Controller states. The fourth code is never entered; it decodes as ERROR.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
// Ports: clk_i clock, clr_i synchronous clear (wins over inc_i),
//        inc_i count-one enable, cnt_o current count.
module sat_counter16 (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= 16'd0;
    end else if (inc_i && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard / memory-wait controller for a 5-stage pipeline: load-use stalls,
// redirect flushes, data-memory freeze with timeout into a sticky ERROR state.
// Ports: clk, rst (sync, active-high); ID/EXE hazard inputs (id_rs, id_rt,
//   ex_memRead, ex_w_addr, ex_redirect); memory handshake (mem_access,
//   dmem_ready, dmem_req); stage enables and flushes (combinational);
//   state, timeout_err, and saturating stall/freeze/flush event counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ASIZE       = DEF_ASIZE,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs,
  input  logic [ASIZE-1:0] id_rt,
  input  logic             ex_memRead,
  input  logic [ASIZE-1:0] ex_w_addr,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             exe_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             dmem_req,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      freeze_cnt,
  output logic [15:0]      flush_cnt
);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       stall_inc, freeze_inc, flush_inc;
  logic       load_use, freeze;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_memRead && (ex_w_addr != '0) &&
                    ((ex_w_addr == id_rs) || (ex_w_addr == id_rt));
  assign freeze   = mem_access && !dmem_ready;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    exe_mem_en    = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    dmem_req      = mem_access;
    state_d       = state_q;
    wait_d        = wait_q;
    stall_inc     = 1'b0;
    freeze_inc    = 1'b0;
    flush_inc     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          {pc_en, if_id_en, id_ex_en, exe_mem_en} = 4'b0000;
          mem_wb_bubble = 1'b1;
          dmem_req      = 1'b1;
          state_d       = ST_MEM_WAIT;
          wait_d        = 8'd1;
        end else if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, bubble into EXE; the load then leaves EXE so
          // the hazard clears after exactly one cycle.
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (!dmem_ready) begin
          {pc_en, if_id_en, id_ex_en, exe_mem_en} = 4'b0000;
          mem_wb_bubble = 1'b1;
          freeze_inc    = 1'b1;
          if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
          if (wait_q == 8'(MEM_TIMEOUT)) state_d = ST_ERROR;
        end else begin
          // Access completes: release the whole pipe; hazards are looked at
          // again only once back in RUN.
          state_d = ST_RUN;
          wait_d  = 8'd0;
        end
      end

      default: begin
        // ERROR and the unused code: pipe held, no memory traffic, until rst.
        {pc_en, if_id_en, id_ex_en, exe_mem_en} = 4'b0000;
        mem_wb_bubble = 1'b1;
        dmem_req      = 1'b0;
        state_d       = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state       = state_q;
  assign timeout_err = state_q[1];  // codes 2 and 3 both mean ERROR

  sat_counter16 u_stall_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_counter16 u_freeze_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (freeze_inc),
    .cnt_o (freeze_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );

endmodule
